clock_period_meter: RTL and testbench

Measures the period (and optionally the high time) of a slow periodic signal, in whole `clk_in` cycles. It is the measuring counterpart of the programmable clock divider: fed a divided clock, it recovers the divisor. Typical uses are divider self-test, and reporting the frequency of an external or derived clock to firmware. It sits in the `clk_in` domain. `meas_in` may be asynchronous to `clk_in`.

---
 rtl/clock_meter_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 32 +++
 rtl/clock_period_meter.sv | 133 +++++++++++++
 tb/tb_clock_period_meter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the clock-monitor blocks (period meter and friends).
package clock_meter_pkg;

  localparam logic [1:0] ENC_IDLE    = 2'd0;
  localparam logic [1:0] ENC_ARMED   = 2'd1;
  localparam logic [1:0] ENC_MEASURE = 2'd2;
  localparam logic [1:0] ENC_STALL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ENC_IDLE,
    ST_ARMED   = ENC_ARMED,
    ST_MEASURE = ENC_MEASURE,
    ST_STALL   = ENC_STALL
  } meter_state_t;

  localparam int SYNC_STAGES_MIN = 2;

  // Fewer than two flops is not a safe synchronizer; quietly round up.
  function automatic int clamp_sync(input int n);
    return (n < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : n;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level plus rising-edge detect.
module sync_edge_detect
  import clock_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic rise
);

  localparam int STAGES = clamp_sync(SYNC_STAGES);

  logic [STAGES-1:0] r_sync;
  logic              r_s_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_s_d  <= r_sync[STAGES-1];
    end
  end

  assign s    = r_sync[STAGES-1];
  assign rise = s & ~r_s_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period (and high time with CLOCK_PERIOD_METER_DUTY_EN defined) of a slow
// signal in clk_in cycles; flags stall when no edge arrives within 2^WIDTH-1 cycles.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             meas_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             stalled,
  output logic             locked
);

  // Last count value from which a rise can still be represented (period = 2^WIDTH-1).
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  meter_state_t     r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_stalled;
  logic             r_locked;
  logic             r_have_prev;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_s;
  logic             w_rise;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .din    (meas_in),
    .s      (w_s),
    .rise   (w_rise)
  );

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_stalled   <= 1'b0;
      r_locked    <= 1'b0;
      r_have_prev <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!enable) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_stalled   <= 1'b0;
        r_locked    <= 1'b0;
        r_have_prev <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_ARMED;
          ST_ARMED: begin
            if (w_rise) begin
              r_cnt       <= '0;
              r_have_prev <= 1'b0;
              r_state     <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (w_rise) begin
              r_period    <= w_cnt_inc;
              r_valid     <= 1'b1;
              r_locked    <= r_have_prev && (w_cnt_inc == r_period);
              r_have_prev <= 1'b1;
              r_cnt       <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state   <= ST_STALL;
              r_stalled <= 1'b1;
              r_locked  <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_STALL: begin
            // The reviving edge only restarts the count; it has no valid start point.
            if (w_rise) begin
              r_state     <= ST_MEASURE;
              r_cnt       <= '0;
              r_stalled   <= 1'b0;
              r_locked    <= 1'b0;
              r_have_prev <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_high;

  // Rise cycle already has s high, so the high count starts at 1.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_high <= '0;
    end else if (!enable || r_state == ST_IDLE) begin
      r_hcnt <= '0;
    end else if (w_rise) begin
      if (r_state == ST_MEASURE) r_high <= r_hcnt;
      r_hcnt <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (r_state == ST_MEASURE && r_cnt != CNT_LAST) begin
      r_hcnt <= r_hcnt + {{(WIDTH-1){1'b0}}, w_s};
    end
  end

  assign high_time = r_high;
`else
  logic w_unused_s;
  assign w_unused_s = w_s;
  assign high_time  = '0;
`endif

  assign period  = r_period;
  assign valid   = r_valid;
  assign stalled = r_stalled;
  assign locked  = r_locked;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: expected results queued at each driven edge,
// compared when valid pulses.
module tb_clock_period_meter;

  localparam int WIDTH = 8;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clk_in  = 1'b0;
  logic             reset   = 1'b1;
  logic             enable  = 1'b0;
  logic             meas_in = 1'b0;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             stalled;
  logic             locked;

  typedef struct {
    int p;
    int h;
    bit lk;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_valid_cyc = -100000;
  logic prev_stalled = 1'b0;
  int   edges = 0;
  int   cur_p = 0;
  int   cur_h = 0;
  int   m_prev = 0;
  bit   m_have = 1'b0;

  clock_period_meter #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .meas_in   (meas_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .stalled   (stalled),
    .locked    (locked)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("period", {24'd0, period}, e.p);
        chk("high_time", {24'd0, high_time}, e.h);
        chk("locked", {31'd0, locked}, {31'd0, e.lk});
      end
      last_valid_cyc = cyc;
    end
    if (stalled === 1'b1 && prev_stalled === 1'b0)
      chk("stall_delay", cyc - last_valid_cyc, 255);
    prev_stalled = stalled;
  endtask

  // One clk_in cycle: sample outputs mid-cycle, then move just past the next edge.
  task automatic tick();
    @(negedge clk_in);
    mon();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic new_session();
    edges  = 0;
    m_have = 1'b0;
  endtask

  // Rising edge, h cycles high, l cycles low; the edge closes the previous period.
  task automatic pulse(input int h, input int l);
    exp_t e;
    if (edges > 0) begin
      e.p    = cur_p;
      e.h    = DUTY ? cur_h : 0;
      e.lk   = m_have && (cur_p == m_prev);
      m_prev = cur_p;
      m_have = 1'b1;
      sbq.push_back(e);
    end
    edges++;
    meas_in = 1'b1;
    repeat (h) tick();
    meas_in = 1'b0;
    repeat (l) tick();
    cur_p = h + l;
    cur_h = h;
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_period", {24'd0, period}, 0);
    chk("rst_high", {24'd0, high_time}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_stalled", {31'd0, stalled}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    reset = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    repeat (3) tick();

    // divide-by-8, then divide-by-2
    repeat (5) pulse(4, 4);
    repeat (6) pulse(1, 1);
    // divisor 8 -> 12
    repeat (3) pulse(4, 4);
    repeat (3) pulse(6, 6);
    // longest measurable period: the rise wins over the stall check
    repeat (3) pulse(100, 155);
    chk("no_stall_255", {31'd0, stalled}, 0);

    // stall: stop after a few divide-by-8 periods
    repeat (3) pulse(4, 4);
    repeat (300) tick();
    chk("stalled_set", {31'd0, stalled}, 1);
    chk("stall_locked", {31'd0, locked}, 0);
    new_session();
    pulse(4, 4);
    chk("stall_cleared", {31'd0, stalled}, 0);
    repeat (2) pulse(4, 4);

    // enable dropped mid-period
    pulse(4, 2);
    enable = 1'b0;
    repeat (10) tick();
    chk("idle_locked", {31'd0, locked}, 0);
    chk("idle_period_hold", {24'd0, period}, 8);
    new_session();
    enable = 1'b1;
    repeat (4) tick();
    repeat (3) pulse(4, 4);

    // async reset mid-MEASURE
    pulse(4, 4);
    meas_in = 1'b1;
    repeat (2) tick();
    @(negedge clk_in);
    #2;
    reset   = 1'b1;
    enable  = 1'b0;
    meas_in = 1'b0;
    #1;
    chk("arst_period", {24'd0, period}, 0);
    chk("arst_high", {24'd0, high_time}, 0);
    chk("arst_valid", {31'd0, valid}, 0);
    chk("arst_stalled", {31'd0, stalled}, 0);
    chk("arst_locked", {31'd0, locked}, 0);
    @(posedge clk_in);
    #1;
    repeat (2) tick();
    reset = 1'b0;
    new_session();
    repeat (3) begin
      meas_in = 1'b1;
      repeat (4) tick();
      meas_in = 1'b0;
      repeat (4) tick();
    end
    chk("idle_after_rst", {24'd0, period}, 0);
    enable = 1'b1;
    repeat (4) tick();
    repeat (4) pulse(4, 4);

    repeat (10) tick();
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
